// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared definitions for the pipelined CPU execute stage.
//   - ALUOp codes (single-cycle and iterative multiply/divide)
//   - ALUSrc codes (operand B / link select)
//   - NPCOp codes (next-PC / branch condition select)
//   - iterative multiply/divide FSM state type and iteration count
package pcpu_pkg;

  // ALUOp codes
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [4:0] ALU_DIVU = 5'd17;
  localparam logic [4:0] ALU_REMU = 5'd18;

  // ALUSrc codes; code 3 is reserved and treated as SRC_REG
  localparam logic [1:0] SRC_REG  = 2'd0;
  localparam logic [1:0] SRC_IMM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;

  // NPCOp codes
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BEQ = 2'd1;
  localparam logic [1:0] NPC_JR  = 2'd2;
  localparam logic [1:0] NPC_BNE = 2'd3;

  // Iterative multiply/divide FSM states (encoding kept fixed)
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int unsigned MULDIV_ITERS = 32;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative 32-bit unsigned multiply / divide, one bit per cycle.
//   MUL  : shift-add, low 32 bits of the product.
//   DIVU : restoring divide, quotient.
//   REMU : restoring divide, remainder.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_start     request; accepted only in IDLE (operands and op latched)
//   i_op        ALUOp code of the request
//   i_a, i_b    operands (a = multiplicand/dividend, b = multiplier/divisor)
//   o_busy      combinational; high on the accepting IDLE cycle and all BUSY cycles
//   o_done      high for the single DONE cycle
//   o_result    result of the latched op, valid while o_done
module muldiv_iter
  import pcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [4:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  md_state_e   r_state;
  logic [4:0]  r_count;
  logic [4:0]  r_op;
  // r_x: multiplicand (MUL) or dividend shifting into quotient (DIV)
  // r_y: multiplier (MUL) or divisor (DIV)
  // r_acc: partial product (MUL) or partial remainder (DIV)
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_acc;

  logic        w_is_mul;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;

  assign w_is_mul = (r_op == ALU_MUL);
  assign w_rem_sh = {r_acc, r_x[31]};
  // Partial remainder stays below the divisor, so bit 32 is a clean borrow flag.
  // A zero divisor never borrows: quotient fills with ones and the remainder
  // ends up equal to the dividend, without a dedicated special case.
  assign w_diff   = w_rem_sh - {1'b0, r_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_count <= '0;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_BUSY;
            r_count <= 5'(MULDIV_ITERS - 1);
            r_op    <= i_op;
            r_x     <= i_a;
            r_y     <= i_b;
            r_acc   <= '0;
          end
        end
        MD_BUSY: begin
          if (w_is_mul) begin
            if (r_y[0]) begin
              r_acc <= r_acc + r_x;
            end
            r_x <= r_x << 1;
            r_y <= r_y >> 1;
          end else if (!w_diff[32]) begin
            r_acc <= w_diff[31:0];
            r_x   <= {r_x[30:0], 1'b1};
          end else begin
            r_acc <= w_rem_sh[31:0];
            r_x   <= {r_x[30:0], 1'b0};
          end
          if (r_count == '0) begin
            r_state <= MD_DONE;
          end else begin
            r_count <= r_count - 5'd1;
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  // Gated by rst_n so a reset mid-operation drops the stall immediately,
  // even while the upstream register still presents the multi-cycle op.
  assign o_busy = rst_n & (((r_state == MD_IDLE) & i_start) | (r_state == MD_BUSY));
  assign o_done = (r_state == MD_DONE);

  always_comb begin
    o_result = '0;
    case (r_op)
      ALU_MUL:  o_result = r_acc;
      ALU_DIVU: o_result = r_x;
      ALU_REMU: o_result = r_acc;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage pipeline.
//   Operand forwarding (MEM over WB over ID/EX, r0 never forwarded), single-cycle
//   ALU, branch/jump-register resolution, iterative multiply/divide with front-end
//   stall, and the EX/MEM pipeline register.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ID_EX_*                           instruction fields from the ID/EX register
//   MEM_wd/MEM_wa/MEM_RegWrite        EX/MEM result fed back for forwarding
//   WB_wd/WB_wa/WB_RegWrite           write-back result fed back for forwarding
//   EX_MEM_*                          registered result and control to MEM
//   branch_taken, branch_target       combinational PC redirect
//   stall                             combinational; holds PC, IF/ID and ID/EX
module ex_stage
  import pcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ID_EX_PC_NEXT,
  input  logic [31:0] ID_EX_rd0_o,
  input  logic [31:0] ID_EX_rd1_o,
  input  logic [31:0] ID_EX_Imm32,
  input  logic [4:0]  ID_EX_ra0,
  input  logic [4:0]  ID_EX_ra1,
  input  logic [1:0]  ID_EX_ALUSrc,
  input  logic [1:0]  ID_EX_MemtoReg,
  input  logic [1:0]  ID_EX_NPCOp,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MemWrite,
  input  logic [4:0]  ID_EX_ALUOp,
  input  logic [4:0]  ID_EX_wa_i,
  input  logic [31:0] MEM_wd,
  input  logic [4:0]  MEM_wa,
  input  logic        MEM_RegWrite,
  input  logic [31:0] WB_wd,
  input  logic [4:0]  WB_wa,
  input  logic        WB_RegWrite,
  output logic [31:0] EX_MEM_alu_out,
  output logic [31:0] EX_MEM_store_data,
  output logic [31:0] EX_MEM_PC_NEXT,
  output logic [4:0]  EX_MEM_wa,
  output logic [1:0]  EX_MEM_MemtoReg,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_MemWrite,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall
);

  logic [31:0] w_a;
  logic [31:0] w_bf;
  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_md_start;
  logic        w_md_busy;
  logic        w_md_done;
  logic [31:0] w_md_result;
  logic        w_taken;
  logic [31:0] w_target;

  logic [31:0] r_alu_out;
  logic [31:0] r_store_data;
  logic [31:0] r_pc_next;
  logic [4:0]  r_wa;
  logic [1:0]  r_memtoreg;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;

  // Forwarding: MEM has priority over WB; register 0 is never forwarded.
  always_comb begin
    w_a = ID_EX_rd0_o;
    if (ID_EX_ra0 != '0 && MEM_RegWrite && MEM_wa == ID_EX_ra0) begin
      w_a = MEM_wd;
    end else if (ID_EX_ra0 != '0 && WB_RegWrite && WB_wa == ID_EX_ra0) begin
      w_a = WB_wd;
    end
  end

  always_comb begin
    w_bf = ID_EX_rd1_o;
    if (ID_EX_ra1 != '0 && MEM_RegWrite && MEM_wa == ID_EX_ra1) begin
      w_bf = MEM_wd;
    end else if (ID_EX_ra1 != '0 && WB_RegWrite && WB_wa == ID_EX_ra1) begin
      w_bf = WB_wd;
    end
  end

  assign w_b = (ID_EX_ALUSrc == SRC_IMM) ? ID_EX_Imm32 : w_bf;

  always_comb begin
    w_alu = '0;
    case (ID_EX_ALUOp)
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_NOR:  w_alu = ~(w_a | w_b);
      ALU_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU: w_alu = {31'd0, w_a < w_b};
      ALU_SLL:  w_alu = w_b << w_a[4:0];
      ALU_SRL:  w_alu = w_b >> w_a[4:0];
      ALU_SRA:  w_alu = $signed(w_b) >>> w_a[4:0];
      ALU_LUI:  w_alu = {w_b[15:0], 16'h0000};
      default:  w_alu = '0;
    endcase
  end

  assign w_md_start = is_muldiv(ID_EX_ALUOp);

  muldiv_iter u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_md_start),
    .i_op     (ID_EX_ALUOp),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  assign stall = w_md_busy;

  always_comb begin
    w_result = w_alu;
    if (ID_EX_ALUSrc == SRC_LINK) begin
      w_result = ID_EX_PC_NEXT;
    end else if (w_md_done) begin
      w_result = w_md_result;
    end
  end

  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    case (ID_EX_NPCOp)
      NPC_BEQ: begin
        w_taken  = (w_a == w_bf);
        w_target = ID_EX_PC_NEXT + {ID_EX_Imm32[29:0], 2'b00};
      end
      NPC_JR: begin
        w_taken  = 1'b1;
        w_target = {w_a[31:2], 2'b00};
      end
      NPC_BNE: begin
        w_taken  = (w_a != w_bf);
        w_target = ID_EX_PC_NEXT + {ID_EX_Imm32[29:0], 2'b00};
      end
      default: begin
        w_taken  = 1'b0;
        w_target = '0;
      end
    endcase
  end

  assign branch_taken  = w_taken & ~stall & rst_n;
  assign branch_target = rst_n ? w_target : '0;

  // EX/MEM register; a stall inserts an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out    <= '0;
      r_store_data <= '0;
      r_pc_next    <= '0;
      r_wa         <= '0;
      r_memtoreg   <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
    end else if (stall) begin
      r_alu_out    <= '0;
      r_store_data <= '0;
      r_pc_next    <= '0;
      r_wa         <= '0;
      r_memtoreg   <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
    end else begin
      r_alu_out    <= w_result;
      r_store_data <= w_bf;
      r_pc_next    <= ID_EX_PC_NEXT;
      r_wa         <= ID_EX_wa_i;
      r_memtoreg   <= ID_EX_MemtoReg;
      r_regwrite   <= ID_EX_RegWrite;
      r_memread    <= ID_EX_MemRead;
      r_memwrite   <= ID_EX_MemWrite;
    end
  end

  assign EX_MEM_alu_out    = r_alu_out;
  assign EX_MEM_store_data = r_store_data;
  assign EX_MEM_PC_NEXT    = r_pc_next;
  assign EX_MEM_wa         = r_wa;
  assign EX_MEM_MemtoReg   = r_memtoreg;
  assign EX_MEM_RegWrite   = r_regwrite;
  assign EX_MEM_MemRead    = r_memread;
  assign EX_MEM_MemWrite   = r_memwrite;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage with directed cases and
// randomized stimulus compared against a behavioural model.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] ID_EX_PC_NEXT, ID_EX_rd0_o, ID_EX_rd1_o, ID_EX_Imm32;
  logic [4:0]  ID_EX_ra0, ID_EX_ra1, ID_EX_ALUOp, ID_EX_wa_i;
  logic [1:0]  ID_EX_ALUSrc, ID_EX_MemtoReg, ID_EX_NPCOp;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
  logic [31:0] MEM_wd, WB_wd;
  logic [4:0]  MEM_wa, WB_wa;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [31:0] EX_MEM_alu_out, EX_MEM_store_data, EX_MEM_PC_NEXT;
  logic [4:0]  EX_MEM_wa;
  logic [1:0]  EX_MEM_MemtoReg;
  logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_a, m_bf, m_res, m_target;
  logic        m_taken;

  ex_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ID_EX_PC_NEXT     (ID_EX_PC_NEXT),
    .ID_EX_rd0_o       (ID_EX_rd0_o),
    .ID_EX_rd1_o       (ID_EX_rd1_o),
    .ID_EX_Imm32       (ID_EX_Imm32),
    .ID_EX_ra0         (ID_EX_ra0),
    .ID_EX_ra1         (ID_EX_ra1),
    .ID_EX_ALUSrc      (ID_EX_ALUSrc),
    .ID_EX_MemtoReg    (ID_EX_MemtoReg),
    .ID_EX_NPCOp       (ID_EX_NPCOp),
    .ID_EX_RegWrite    (ID_EX_RegWrite),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_MemWrite    (ID_EX_MemWrite),
    .ID_EX_ALUOp       (ID_EX_ALUOp),
    .ID_EX_wa_i        (ID_EX_wa_i),
    .MEM_wd            (MEM_wd),
    .MEM_wa            (MEM_wa),
    .MEM_RegWrite      (MEM_RegWrite),
    .WB_wd             (WB_wd),
    .WB_wa             (WB_wa),
    .WB_RegWrite       (WB_RegWrite),
    .EX_MEM_alu_out    (EX_MEM_alu_out),
    .EX_MEM_store_data (EX_MEM_store_data),
    .EX_MEM_PC_NEXT    (EX_MEM_PC_NEXT),
    .EX_MEM_wa         (EX_MEM_wa),
    .EX_MEM_MemtoReg   (EX_MEM_MemtoReg),
    .EX_MEM_RegWrite   (EX_MEM_RegWrite),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_MemWrite   (EX_MEM_MemWrite),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .stall             (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] idv);
    if (ra == 5'd0) return idv;
    if (MEM_RegWrite && MEM_wa == ra) return MEM_wd;
    if (WB_RegWrite && WB_wa == ra) return WB_wd;
    return idv;
  endfunction

  function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones, r;
    logic [63:0] p;
    sh   = a % 32;
    ones = 32'hFFFFFFFF;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return ~(a | b);
      5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:  return (a < b) ? 32'd1 : 32'd0;
      5'd8:  return b << sh;
      5'd9:  return b >> sh;
      5'd10: begin
        r = b >> sh;
        if (b[31] && sh != 0) r = r | ~(ones >> sh);
        return r;
      end
      5'd11: return b << 16;
      5'd16: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      5'd17: return (b == 0) ? ones : a / b;
      5'd18: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_eval();
    logic [31:0] b;
    m_a  = fwd(ID_EX_ra0, ID_EX_rd0_o);
    m_bf = fwd(ID_EX_ra1, ID_EX_rd1_o);
    b    = (ID_EX_ALUSrc == 2'd1) ? ID_EX_Imm32 : m_bf;
    m_res = (ID_EX_ALUSrc == 2'd2) ? ID_EX_PC_NEXT : model_alu(ID_EX_ALUOp, m_a, b);
    m_taken  = 1'b0;
    m_target = 32'd0;
    case (ID_EX_NPCOp)
      2'd1: begin m_taken = (m_a == m_bf); m_target = ID_EX_PC_NEXT + ID_EX_Imm32 * 4; end
      2'd2: begin m_taken = 1'b1;          m_target = m_a - (m_a % 4); end
      2'd3: begin m_taken = (m_a != m_bf); m_target = ID_EX_PC_NEXT + ID_EX_Imm32 * 4; end
      default: ;
    endcase
  endtask

  function automatic logic [41:0] exp_ctrl();
    return {ID_EX_PC_NEXT, ID_EX_wa_i, ID_EX_MemtoReg, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite};
  endfunction

  function automatic logic [41:0] out_ctrl();
    return {EX_MEM_PC_NEXT, EX_MEM_wa, EX_MEM_MemtoReg, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    ID_EX_PC_NEXT = '0; ID_EX_rd0_o = '0; ID_EX_rd1_o = '0; ID_EX_Imm32 = '0;
    ID_EX_ra0 = '0; ID_EX_ra1 = '0; ID_EX_ALUOp = '0; ID_EX_wa_i = '0;
    ID_EX_ALUSrc = '0; ID_EX_MemtoReg = '0; ID_EX_NPCOp = '0;
    ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_MemWrite = 1'b0;
    MEM_wd = '0; MEM_wa = '0; MEM_RegWrite = 1'b0;
    WB_wd = '0; WB_wa = '0; WB_RegWrite = 1'b0;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    ID_EX_ALUOp    = op;
    ID_EX_rd0_o    = a;
    ID_EX_rd1_o    = b;
    ID_EX_RegWrite = 1'b1;
    ID_EX_wa_i     = 5'd9;
    ID_EX_PC_NEXT  = 32'h0000_1000;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 40));
      2:       return 32'hFFFFFFFF - 32'($urandom_range(0, 40));
      default: return 32'h80000000;
    endcase
  endfunction

  task automatic randomize_inputs(input bit md);
    ID_EX_PC_NEXT  = $urandom;
    ID_EX_Imm32    = ($urandom_range(0, 1) == 1) ? $urandom : pick_val();
    ID_EX_rd0_o    = pick_val();
    ID_EX_rd1_o    = ($urandom_range(0, 3) == 0) ? ID_EX_rd0_o : pick_val();
    ID_EX_ra0      = 5'($urandom_range(0, 3));
    ID_EX_ra1      = 5'($urandom_range(0, 3));
    MEM_wa         = 5'($urandom_range(0, 3));
    WB_wa          = 5'($urandom_range(0, 3));
    MEM_RegWrite   = 1'($urandom);
    WB_RegWrite    = 1'($urandom);
    MEM_wd         = pick_val();
    WB_wd          = pick_val();
    ID_EX_wa_i     = 5'($urandom);
    ID_EX_MemtoReg = 2'($urandom);
    ID_EX_RegWrite = 1'($urandom);
    ID_EX_MemRead  = 1'($urandom);
    ID_EX_MemWrite = 1'($urandom);
    ID_EX_NPCOp    = 2'($urandom);
    if (md) begin
      ID_EX_ALUOp  = 5'(16 + $urandom_range(0, 2));
      ID_EX_ALUSrc = 2'($urandom_range(0, 1));
    end else begin
      ID_EX_ALUOp  = 5'($urandom_range(0, 15));
      ID_EX_ALUSrc = 2'($urandom);
    end
  endtask

  // Inputs are set away from the clock edge before calling.
  task automatic run_single(input string tag);
    model_eval();
    #1;
    check_eq({tag, "_stall"}, stall, 1'b0);
    check_eq({tag, "_bt"}, branch_taken, m_taken);
    if (m_taken) check_eq({tag, "_tgt"}, branch_target, m_target);
    @(posedge clk); #1;
    check_eq({tag, "_res"}, EX_MEM_alu_out, m_res);
    check_eq({tag, "_sd"}, EX_MEM_store_data, m_bf);
    check_eq({tag, "_ctl"}, out_ctrl(), exp_ctrl());
  endtask

  task automatic run_muldiv(input string tag);
    logic [31:0] mem_save, wb_save;
    int cyc;
    model_eval();
    mem_save = MEM_wd;
    wb_save  = WB_wd;
    #1;
    check_eq({tag, "_bt_supp"}, branch_taken, 1'b0);
    cyc = 0;
    while (stall === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
      // operands are frozen once the op is accepted; disturb the feedback paths
      MEM_wd = $urandom;
      WB_wd  = $urandom;
      check_eq({tag, "_bubble"}, {EX_MEM_alu_out, EX_MEM_store_data, out_ctrl()}, 128'd0);
    end
    check_eq({tag, "_stall_cycles"}, cyc, 33);
    MEM_wd = mem_save;
    WB_wd  = wb_save;
    @(posedge clk); #1;
    check_eq({tag, "_res"}, EX_MEM_alu_out, m_res);
    check_eq({tag, "_sd"}, EX_MEM_store_data, m_bf);
    check_eq({tag, "_ctl"}, out_ctrl(), exp_ctrl());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_regs", {EX_MEM_alu_out, EX_MEM_store_data, out_ctrl()}, 128'd0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_bt", branch_taken, 1'b0);
    rst_n = 1'b1;

    // forwarding priority
    set_op(5'd0, 32'd20, 32'd3);
    ID_EX_ra0 = 5'd5; ID_EX_ra1 = 5'd7;
    MEM_wa = 5'd5; MEM_wd = 32'd10; MEM_RegWrite = 1'b1;
    WB_wa  = 5'd5; WB_wd  = 32'd99; WB_RegWrite  = 1'b1;
    run_single("add_fwd");
    check_eq("add_fwd_lit", EX_MEM_alu_out, 32'd13);
    ID_EX_ra0 = 5'd0;
    run_single("add_r0");
    check_eq("add_r0_lit", EX_MEM_alu_out, 32'd23);

    set_op(5'd6, 32'hFFFFFFFF, 32'd1);
    run_single("slt");
    check_eq("slt_lit", EX_MEM_alu_out, 32'd1);
    set_op(5'd7, 32'hFFFFFFFF, 32'd1);
    run_single("sltu");
    check_eq("sltu_lit", EX_MEM_alu_out, 32'd0);
    set_op(5'd10, 32'd4, 32'h80000000);
    run_single("sra");
    check_eq("sra_lit", EX_MEM_alu_out, 32'hF8000000);

    set_op(5'd1, 32'd77, 32'd77);
    ID_EX_NPCOp = 2'd1; ID_EX_PC_NEXT = 32'h104; ID_EX_Imm32 = 32'd3;
    #1;
    check_eq("beq_bt_lit", branch_taken, 1'b1);
    check_eq("beq_tgt_lit", branch_target, 32'h110);
    run_single("beq");
    set_op(5'd0, 32'h203, 32'd0);
    ID_EX_NPCOp = 2'd2;
    #1;
    check_eq("jr_tgt_lit", branch_target, 32'h200);
    run_single("jr");

    // multi-cycle, back to back
    set_op(5'd16, 32'h00010001, 32'h00010001);
    run_muldiv("mul");
    check_eq("mul_lit", EX_MEM_alu_out, 32'h00020001);
    set_op(5'd17, 32'd100, 32'd7);
    run_muldiv("divu");
    check_eq("divu_lit", EX_MEM_alu_out, 32'd14);
    set_op(5'd18, 32'd100, 32'd7);
    run_muldiv("remu");
    check_eq("remu_lit", EX_MEM_alu_out, 32'd2);
    set_op(5'd17, 32'hDEADBEEF, 32'd0);
    run_muldiv("divu0");
    check_eq("divu0_lit", EX_MEM_alu_out, 32'hFFFFFFFF);
    set_op(5'd18, 32'hDEADBEEF, 32'd0);
    run_muldiv("remu0");
    check_eq("remu0_lit", EX_MEM_alu_out, 32'hDEADBEEF);

    // randomized
    for (int i = 0; i < 6; i++) begin
      randomize_inputs(1'b1);
      run_muldiv("rnd_md");
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        randomize_inputs(1'b1);
        run_muldiv("rnd_md");
      end else begin
        randomize_inputs(1'b0);
        run_single("rnd");
      end
    end

    // reset in the middle of a multiply
    set_op(5'd16, 32'h1234, 32'h5678);
    #1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_stall", stall, 1'b0);
    check_eq("midrst_bt", branch_taken, 1'b0);
    check_eq("midrst_regs", {EX_MEM_alu_out, EX_MEM_store_data, out_ctrl()}, 128'd0);
    set_op(5'd0, 32'd40, 32'd2);
    @(posedge clk); #1;
    check_eq("midrst_hold", {EX_MEM_alu_out, EX_MEM_store_data, out_ctrl()}, 128'd0);
    rst_n = 1'b1;
    run_single("post_rst_add");
    check_eq("post_rst_lit", EX_MEM_alu_out, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
